// File: rtl/m_axi_lite_if.sv
// m_axi_lite_if: AXI4-Lite bus bundle between one initiator and one target.
//   Parameters: P_DATA_WIDTH (multiple of 8), P_ADDR_WIDTH.
//   Channels: AW (awaddr/awprot/awvalid/awready), W (wdata/wstrb/wvalid/wready),
//             B (bresp/bvalid/bready), AR (araddr/arprot/arvalid/arready),
//             R (rdata/rresp/rvalid/rready).
//   Modports: master (initiator side), slave (target side).
interface m_axi_lite_if #(
  parameter int unsigned P_DATA_WIDTH = 32,
  parameter int unsigned P_ADDR_WIDTH = 4
);
  localparam int unsigned STRB_W = P_DATA_WIDTH / 8;

  logic [P_ADDR_WIDTH-1:0] awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;

  logic [P_DATA_WIDTH-1:0] wdata;
  logic [STRB_W-1:0]       wstrb;
  logic                    wvalid;
  logic                    wready;

  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  logic [P_ADDR_WIDTH-1:0] araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;

  logic [P_DATA_WIDTH-1:0] rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid,    input wready,
    input  bresp, bvalid,           output bready,
    output araddr, arprot, arvalid, input arready,
    input  rdata, rresp, rvalid,    output rready
  );

  modport slave (
    input  awaddr, awprot, awvalid, output awready,
    input  wdata, wstrb, wvalid,    output wready,
    output bresp, bvalid,           input bready,
    input  araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid,    input rready
  );
endinterface

// File: rtl/m_axi_lite.sv
// m_axi_lite: single-outstanding AXI4-Lite initiator. Each accepted command
// becomes one write (AW+W+B) or one read (AR+R); completion is reported as a
// one-cycle response pulse whose fields hold until the next completion.
//   Clock/reset : M_AXI_ACLK, M_AXI_ARESETN (synchronous, active-low)
//   Command     : i_cmd_valid/o_cmd_ready, i_cmd_wr, i_cmd_addr, i_cmd_wdata,
//                 i_cmd_wstrb
//   Response    : o_rsp_valid, o_rsp_wr, o_rsp_rdata, o_rsp_resp, o_rsp_timeout
//   Bus         : m_axi (m_axi_lite_if.master)
// Optional feature macro: M_AXI_LITE_TIMEOUT_EN enables an 8-bit watchdog that
// aborts a stuck transaction after P_TIMEOUT_CYCLES cycles outside IDLE and
// reports resp=2'b10 with o_rsp_timeout=1. Without it the block waits forever.
module m_axi_lite #(
  parameter int unsigned P_M_AXI_DATA_WIDTH = 32,
  parameter int unsigned P_M_AXI_ADDR_WIDTH = 4,
  parameter int unsigned P_TIMEOUT_CYCLES   = 255
) (
  input  logic                              M_AXI_ACLK,
  input  logic                              M_AXI_ARESETN,
  input  logic                              i_cmd_valid,
  output logic                              o_cmd_ready,
  input  logic                              i_cmd_wr,
  input  logic [P_M_AXI_ADDR_WIDTH-1:0]     i_cmd_addr,
  input  logic [P_M_AXI_DATA_WIDTH-1:0]     i_cmd_wdata,
  input  logic [P_M_AXI_DATA_WIDTH/8-1:0]   i_cmd_wstrb,
  output logic                              o_rsp_valid,
  output logic                              o_rsp_wr,
  output logic [P_M_AXI_DATA_WIDTH-1:0]     o_rsp_rdata,
  output logic [1:0]                        o_rsp_resp,
  output logic                              o_rsp_timeout,
  m_axi_lite_if.master                      m_axi
);
  localparam int unsigned DW    = P_M_AXI_DATA_WIDTH;
  localparam int unsigned AW    = P_M_AXI_ADDR_WIDTH;
  localparam int unsigned SW    = DW / 8;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4
  } state_e;

  state_e          state_q,   state_d;
  logic            awvalid_q, awvalid_d;
  logic            wvalid_q,  wvalid_d;
  logic            bready_q,  bready_d;
  logic            arvalid_q, arvalid_d;
  logic            rready_q,  rready_d;
  logic [AW-1:0]   awaddr_q,  awaddr_d;
  logic [AW-1:0]   araddr_q,  araddr_d;
  logic [DW-1:0]   wdata_q,   wdata_d;
  logic [SW-1:0]   wstrb_q,   wstrb_d;
  logic            rsp_valid_q,   rsp_valid_d;
  logic            rsp_wr_q,      rsp_wr_d;
  logic [DW-1:0]   rsp_rdata_q,   rsp_rdata_d;
  logic [1:0]      rsp_resp_q,    rsp_resp_d;
  logic            rsp_timeout_q, rsp_timeout_d;
  logic            cmd_fire_c;

`ifdef M_AXI_LITE_TIMEOUT_EN
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             tmo_hit_c;
  // Counter equals the number of edges spent outside IDLE; abort on the edge it would reach the limit.
  assign tmo_hit_c = (state_q != IDLE) && (tmo_cnt_q == CNT_W'(P_TIMEOUT_CYCLES - 1));
`else
  wire [31:0] unused_tmo_cfg = 32'(P_TIMEOUT_CYCLES) + 32'(CNT_W);
`endif

  assign o_cmd_ready = (state_q == IDLE) && M_AXI_ARESETN;
  assign cmd_fire_c  = i_cmd_valid && o_cmd_ready;

  // Next-state and next-output logic.
  always_comb begin
    state_d       = state_q;
    awvalid_d     = awvalid_q;
    wvalid_d      = wvalid_q;
    bready_d      = bready_q;
    arvalid_d     = arvalid_q;
    rready_d      = rready_q;
    awaddr_d      = awaddr_q;
    araddr_d      = araddr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    rsp_valid_d   = 1'b0;
    rsp_wr_d      = rsp_wr_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_resp_d    = rsp_resp_q;
    rsp_timeout_d = rsp_timeout_q;
`ifdef M_AXI_LITE_TIMEOUT_EN
    tmo_cnt_d     = tmo_cnt_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (cmd_fire_c) begin
          awaddr_d = i_cmd_addr;
          araddr_d = i_cmd_addr;
          wdata_d  = i_cmd_wdata;
          wstrb_d  = i_cmd_wstrb;
          if (i_cmd_wr) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR_REQ;
          end else begin
            arvalid_d = 1'b1;
            state_d   = RD_REQ;
          end
        end
      end
      WR_REQ: begin
        // AW and W complete independently; move on once both have dropped.
        if (awvalid_q && m_axi.awready) awvalid_d = 1'b0;
        if (wvalid_q && m_axi.wready)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = WR_RESP;
        end
      end
      WR_RESP: begin
        if (bready_q && m_axi.bvalid) begin
          bready_d      = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_wr_d      = 1'b1;
          rsp_rdata_d   = '0;
          rsp_resp_d    = m_axi.bresp;
          rsp_timeout_d = 1'b0;
          state_d       = IDLE;
        end
      end
      RD_REQ: begin
        if (arvalid_q && m_axi.arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_RESP;
        end
      end
      RD_RESP: begin
        if (rready_q && m_axi.rvalid) begin
          rready_d      = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_wr_d      = 1'b0;
          rsp_rdata_d   = m_axi.rdata;
          rsp_resp_d    = m_axi.rresp;
          rsp_timeout_d = 1'b0;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef M_AXI_LITE_TIMEOUT_EN
    if (cmd_fire_c) begin
      tmo_cnt_d = '0;
    end else if (state_q != IDLE) begin
      tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
    end
    // A genuine completion on the same edge takes precedence over the abort.
    if (tmo_hit_c && !rsp_valid_d) begin
      awvalid_d     = 1'b0;
      wvalid_d      = 1'b0;
      bready_d      = 1'b0;
      arvalid_d     = 1'b0;
      rready_d      = 1'b0;
      rsp_valid_d   = 1'b1;
      rsp_wr_d      = (state_q == WR_REQ) || (state_q == WR_RESP);
      rsp_rdata_d   = '0;
      rsp_resp_d    = 2'b10;
      rsp_timeout_d = 1'b1;
      state_d       = IDLE;
    end
`endif
  end

  // State and output registers.
  always_ff @(posedge M_AXI_ACLK) begin
    if (!M_AXI_ARESETN) begin
      state_q       <= IDLE;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      awaddr_q      <= '0;
      araddr_q      <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_wr_q      <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= 2'b00;
      rsp_timeout_q <= 1'b0;
`ifdef M_AXI_LITE_TIMEOUT_EN
      tmo_cnt_q     <= '0;
`endif
    end else begin
      state_q       <= state_d;
      awvalid_q     <= awvalid_d;
      wvalid_q      <= wvalid_d;
      bready_q      <= bready_d;
      arvalid_q     <= arvalid_d;
      rready_q      <= rready_d;
      awaddr_q      <= awaddr_d;
      araddr_q      <= araddr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_wr_q      <= rsp_wr_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_resp_q    <= rsp_resp_d;
      rsp_timeout_q <= rsp_timeout_d;
`ifdef M_AXI_LITE_TIMEOUT_EN
      tmo_cnt_q     <= tmo_cnt_d;
`endif
    end
  end

  assign m_axi.awaddr  = awaddr_q;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.awvalid = awvalid_q;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = wstrb_q;
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.bready  = bready_q;
  assign m_axi.araddr  = araddr_q;
  assign m_axi.arprot  = 3'b000;
  assign m_axi.arvalid = arvalid_q;
  assign m_axi.rready  = rready_q;

  assign o_rsp_valid   = rsp_valid_q;
  assign o_rsp_wr      = rsp_wr_q;
  assign o_rsp_rdata   = rsp_rdata_q;
  assign o_rsp_resp    = rsp_resp_q;
  assign o_rsp_timeout = rsp_timeout_q;
endmodule

// File: tb/tb_m_axi_lite.sv
// tb_m_axi_lite: bench for m_axi_lite with a small register-file target on the
// bus, a table of directed transactions, hand-written reset/idle sequences,
// and randomized traffic checked against a memory/latency reference model.
module tb_m_axi_lite;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 4;
  localparam int unsigned SW = DW / 8;

  logic          clk = 1'b0;
  logic          rstn;
  logic          i_cmd_valid;
  logic          o_cmd_ready;
  logic          i_cmd_wr;
  logic [AW-1:0] i_cmd_addr;
  logic [DW-1:0] i_cmd_wdata;
  logic [SW-1:0] i_cmd_wstrb;
  logic          o_rsp_valid;
  logic          o_rsp_wr;
  logic [DW-1:0] o_rsp_rdata;
  logic [1:0]    o_rsp_resp;
  logic          o_rsp_timeout;

  always #5 clk = ~clk;

  m_axi_lite_if #(.P_DATA_WIDTH(DW), .P_ADDR_WIDTH(AW)) bus ();

  m_axi_lite #(
    .P_M_AXI_DATA_WIDTH(DW),
    .P_M_AXI_ADDR_WIDTH(AW),
    .P_TIMEOUT_CYCLES  (16)
  ) dut (
    .M_AXI_ACLK   (clk),
    .M_AXI_ARESETN(rstn),
    .i_cmd_valid  (i_cmd_valid),
    .o_cmd_ready  (o_cmd_ready),
    .i_cmd_wr     (i_cmd_wr),
    .i_cmd_addr   (i_cmd_addr),
    .i_cmd_wdata  (i_cmd_wdata),
    .i_cmd_wstrb  (i_cmd_wstrb),
    .o_rsp_valid  (o_rsp_valid),
    .o_rsp_wr     (o_rsp_wr),
    .o_rsp_rdata  (o_rsp_rdata),
    .o_rsp_resp   (o_rsp_resp),
    .o_rsp_timeout(o_rsp_timeout),
    .m_axi        (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] mem_slv [4];
  logic [31:0] mem_mdl [4];

  typedef struct {
    logic        done;
    logic        wr;
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic        to;
    int          lat;
    int          vcyc;
    int          wcyc;
    int          rdycyc;
    logic        viol;
  } res_t;

  typedef struct {
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] wd;
    logic [3:0]  ws;
    int          da, dw, db, dar, dr;
    logic [1:0]  bresp, rresp;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
    int          exp_lat, exp_v, exp_w, exp_rdy;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] apply_strb(input logic [31:0] old, input logic [31:0] d,
                                             input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  task automatic clear_slave();
    bus.awready = 1'b0; bus.wready = 1'b0;
    bus.bvalid  = 1'b0; bus.bresp  = 2'b00;
    bus.arready = 1'b0;
    bus.rvalid  = 1'b0; bus.rresp  = 2'b00; bus.rdata = 32'h0;
  endtask

  // Issue one command and play the target side until the response pulse.
  // Called at posedge+1 of a cycle where the DUT should be idle.
  task automatic do_txn(input logic wr, input logic [3:0] addr, input logic [31:0] wd,
                        input logic [3:0] ws, input int da, input int dw, input int db,
                        input int dar, input int dr, input logic [1:0] bresp,
                        input logic [1:0] rresp, output res_t r);
    int aw_n, w_n, b_n, ar_n, r_n, cyc;
    logic [3:0]  h_awaddr, h_araddr;
    logic [31:0] h_wdata;
    logic [3:0]  h_wstrb;
    logic        p_wr, p_to;
    logic [31:0] p_rdata;
    logic [1:0]  p_resp;
    aw_n = 0; w_n = 0; b_n = 0; ar_n = 0; r_n = 0; cyc = 0;
    h_awaddr = '0; h_araddr = '0; h_wdata = '0; h_wstrb = '0;
    r = '{default: 0};
    p_wr = o_rsp_wr; p_rdata = o_rsp_rdata; p_resp = o_rsp_resp; p_to = o_rsp_timeout;
    if (o_cmd_ready !== 1'b1) r.viol = 1'b1;
    i_cmd_valid = 1'b1; i_cmd_wr = wr; i_cmd_addr = addr; i_cmd_wdata = wd; i_cmd_wstrb = ws;
    while (!r.done && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      i_cmd_valid = 1'b0;
      if (bus.awvalid) begin
        aw_n++;
        if (bus.awaddr !== addr) r.viol = 1'b1;
        bus.awready = (aw_n > da);
        if (bus.awready) h_awaddr = bus.awaddr;
      end else bus.awready = 1'b0;
      if (bus.wvalid) begin
        w_n++;
        if (bus.wdata !== wd || bus.wstrb !== ws) r.viol = 1'b1;
        bus.wready = (w_n > dw);
        if (bus.wready) begin h_wdata = bus.wdata; h_wstrb = bus.wstrb; end
      end else bus.wready = 1'b0;
      if (bus.bready) begin
        b_n++;
        bus.bvalid = (b_n > db);
        bus.bresp  = bresp;
        if (bus.bvalid) mem_slv[h_awaddr[3:2]] = apply_strb(mem_slv[h_awaddr[3:2]], h_wdata, h_wstrb);
      end else bus.bvalid = 1'b0;
      if (bus.arvalid) begin
        ar_n++;
        if (bus.araddr !== addr) r.viol = 1'b1;
        bus.arready = (ar_n > dar);
        if (bus.arready) h_araddr = bus.araddr;
      end else bus.arready = 1'b0;
      if (bus.rready) begin
        r_n++;
        bus.rvalid = (r_n > dr);
        bus.rresp  = rresp;
        bus.rdata  = bus.rvalid ? mem_slv[h_araddr[3:2]] : 32'hDEAD_0000;
      end else bus.rvalid = 1'b0;
      if (bus.awprot !== 3'b000 || bus.arprot !== 3'b000) r.viol = 1'b1;
      if (wr && (bus.arvalid || bus.rready)) r.viol = 1'b1;
      if (!wr && (bus.awvalid || bus.wvalid || bus.bready)) r.viol = 1'b1;
      if (bus.bready && (bus.awvalid || bus.wvalid)) r.viol = 1'b1;
      if (bus.rready && bus.arvalid) r.viol = 1'b1;
      if (o_cmd_ready !== o_rsp_valid) r.viol = 1'b1;
      if (o_rsp_valid) begin
        r.done = 1'b1; r.wr = o_rsp_wr; r.rdata = o_rsp_rdata;
        r.resp = o_rsp_resp; r.to = o_rsp_timeout; r.lat = cyc;
      end else if (o_rsp_wr !== p_wr || o_rsp_rdata !== p_rdata ||
                   o_rsp_resp !== p_resp || o_rsp_timeout !== p_to) begin
        r.viol = 1'b1;
      end
    end
    r.vcyc   = wr ? aw_n : ar_n;
    r.wcyc   = w_n;
    r.rdycyc = wr ? b_n : r_n;
  endtask

  task automatic check_res(input string tag, input res_t r, input logic wr,
                           input logic [31:0] rd, input logic [1:0] resp, input logic to,
                           input int lat, input int v, input int w, input int rdy);
    chk({tag, ".done"},    64'(r.done),   64'(1));
    chk({tag, ".rsp_wr"},  64'(r.wr),     64'(wr));
    chk({tag, ".rdata"},   64'(r.rdata),  64'(rd));
    chk({tag, ".resp"},    64'(r.resp),   64'(resp));
    chk({tag, ".timeout"}, 64'(r.to),     64'(to));
    chk({tag, ".latency"}, 64'(r.lat),    64'(lat));
    chk({tag, ".vcycles"}, 64'(r.vcyc),   64'(v));
    chk({tag, ".wcycles"}, 64'(r.wcyc),   64'(w));
    chk({tag, ".rdycyc"},  64'(r.rdycyc), 64'(rdy));
    chk({tag, ".protocol"}, 64'(r.viol),  64'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    vec_t  vec [8];
    res_t  r;
    logic  wr;
    logic [3:0]  addr, ws;
    logic [31:0] wd, erd;
    logic [1:0]  bresp, rresp;
    int da, dw, db, dar, dr;

    for (int k = 0; k < 4; k++) begin mem_slv[k] = '0; mem_mdl[k] = '0; end
    clear_slave();

    //            wr    addr   wdata         strb  da dw db dar dr bresp  rresp  exp_rdata     resp   lat v w rdy
    vec[0] = '{1'b1, 4'h4, 32'hA5A5_0001, 4'hF, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0,         2'b00, 3, 1, 1, 1};
    vec[1] = '{1'b0, 4'h4, 32'h0,         4'h0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'hA5A5_0001, 2'b00, 3, 1, 0, 1};
    vec[2] = '{1'b1, 4'h8, 32'h1234_5678, 4'hF, 3, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0,         2'b00, 6, 4, 1, 1};
    vec[3] = '{1'b1, 4'h8, 32'hFFFF_FFFF, 4'h5, 0, 2, 1, 0, 0, 2'b01, 2'b00, 32'h0,         2'b01, 6, 1, 3, 2};
    vec[4] = '{1'b0, 4'h8, 32'h0,         4'h0, 0, 0, 0, 2, 4, 2'b00, 2'b10, 32'h12FF_56FF, 2'b10, 9, 3, 0, 5};
    vec[5] = '{1'b0, 4'hC, 32'h0,         4'h0, 0, 0, 0, 0, 1, 2'b00, 2'b11, 32'h0,         2'b11, 4, 1, 0, 2};
    vec[6] = '{1'b1, 4'h0, 32'hDEAD_BEEF, 4'h3, 1, 1, 0, 0, 0, 2'b00, 2'b00, 32'h0,         2'b00, 4, 2, 2, 1};
    vec[7] = '{1'b0, 4'h0, 32'h0,         4'h0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0000_BEEF, 2'b00, 3, 1, 0, 1};

    // Reset state, with a command pending that must not be taken.
    rstn = 1'b0;
    i_cmd_valid = 1'b1; i_cmd_wr = 1'b1; i_cmd_addr = 4'h4;
    i_cmd_wdata = 32'h1; i_cmd_wstrb = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.bus", {bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready,
                      bus.awaddr, bus.araddr, bus.wdata, bus.wstrb}, 64'h0);
    chk("reset.rsp", {o_rsp_valid, o_rsp_wr, o_rsp_rdata, o_rsp_resp, o_rsp_timeout, o_cmd_ready},
        64'h0);
    i_cmd_valid = 1'b0;
    rstn = 1'b1;
    @(posedge clk); #1;
    chk("post_reset.ready_no_accept", {62'h0, o_cmd_ready, bus.awvalid}, 64'h2);

    // Directed table.
    for (int i = 0; i < 8; i++) begin
      do_txn(vec[i].wr, vec[i].addr, vec[i].wd, vec[i].ws, vec[i].da, vec[i].dw, vec[i].db,
             vec[i].dar, vec[i].dr, vec[i].bresp, vec[i].rresp, r);
      if (vec[i].wr) mem_mdl[vec[i].addr[3:2]] = apply_strb(mem_mdl[vec[i].addr[3:2]], vec[i].wd, vec[i].ws);
      check_res($sformatf("vec%0d", i), r, vec[i].wr, vec[i].exp_rdata, vec[i].exp_resp, 1'b0,
                vec[i].exp_lat, vec[i].exp_v, vec[i].exp_w, vec[i].exp_rdy);
    end

    // Reset while waiting for B: everything returns to reset values, no pulse.
    i_cmd_valid = 1'b1; i_cmd_wr = 1'b1; i_cmd_addr = 4'h4;
    i_cmd_wdata = 32'h1111_2222; i_cmd_wstrb = 4'hF;
    @(posedge clk); #1;
    i_cmd_valid = 1'b0;
    chk("mid.aw_w_valid", {62'h0, bus.awvalid, bus.wvalid}, 64'h3);
    bus.awready = 1'b1; bus.wready = 1'b1;
    @(posedge clk); #1;
    clear_slave();
    chk("mid.in_wr_resp", {62'h0, bus.bready, bus.awvalid}, 64'h2);
    rstn = 1'b0;
    @(posedge clk); #1;
    chk("mid.reset.bus", {bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready,
                          bus.awaddr, bus.araddr, bus.wdata, bus.wstrb}, 64'h0);
    chk("mid.reset.rsp", {o_rsp_valid, o_rsp_wr, o_rsp_rdata, o_rsp_resp, o_rsp_timeout, o_cmd_ready},
        64'h0);
    rstn = 1'b1;
    // Unsolicited B/R responses while idle are ignored.
    bus.bvalid = 1'b1; bus.rvalid = 1'b1; bus.bresp = 2'b11; bus.rresp = 2'b11;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk($sformatf("idle_unsolicited%0d", c), {61'h0, bus.bready, bus.rready, o_rsp_valid}, 64'h0);
    end
    clear_slave();
    do_txn(1'b1, 4'hC, 32'hCAFE_F00D, 4'hF, 0, 0, 0, 0, 0, 2'b00, 2'b00, r);
    mem_mdl[3] = apply_strb(mem_mdl[3], 32'hCAFE_F00D, 4'hF);
    check_res("after_reset_wr", r, 1'b1, 32'h0, 2'b00, 1'b0, 3, 1, 1, 1);
    do_txn(1'b0, 4'h4, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b00, 2'b00, r);
    check_res("after_reset_rd", r, 1'b0, mem_mdl[1], 2'b00, 1'b0, 3, 1, 0, 1);

`ifdef M_AXI_LITE_TIMEOUT_EN
    // Target never accepts AR: abort after 16 cycles of ARVALID.
    do_txn(1'b0, 4'h4, 32'h0, 4'h0, 0, 0, 0, 1000, 0, 2'b00, 2'b00, r);
    check_res("timeout_rd", r, 1'b0, 32'h0, 2'b10, 1'b1, 17, 16, 0, 0);
`endif

    // Randomized back-to-back traffic against the reference model.
    for (int i = 0; i < 40; i++) begin
      wr    = 1'($urandom_range(0, 1));
      addr  = 4'($urandom);
      wd    = $urandom;
      ws    = 4'($urandom);
      da    = $urandom_range(0, 3);
      dw    = $urandom_range(0, 3);
      db    = $urandom_range(0, 3);
      dar   = $urandom_range(0, 3);
      dr    = $urandom_range(0, 3);
      bresp = 2'($urandom);
      rresp = 2'($urandom);
      do_txn(wr, addr, wd, ws, da, dw, db, dar, dr, bresp, rresp, r);
      if (wr) begin
        mem_mdl[addr[3:2]] = apply_strb(mem_mdl[addr[3:2]], wd, ws);
        check_res($sformatf("rnd%0d_wr", i), r, 1'b1, 32'h0, bresp, 1'b0,
                  3 + ((da > dw) ? da : dw) + db, da + 1, dw + 1, db + 1);
      end else begin
        erd = mem_mdl[addr[3:2]];
        check_res($sformatf("rnd%0d_rd", i), r, 1'b0, erd, rresp, 1'b0,
                  3 + dar + dr, dar + 1, 0, dr + 1);
      end
    end

    @(posedge clk); #1;
    chk("final.no_pulse", {63'h0, o_rsp_valid}, 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
